data_mem_sized: RTL and testbench

DATA_MEM_SIZED -- requirements
Module: data_mem_sized

---
 rtl/dm_pkg.sv | 35 +++
 rtl/dm_byte_array.sv | 26 ++
 rtl/data_mem_sized.sv | 92 +++++++++
 tb/tb_data_mem_sized.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size/state encodings, latency and depth bounds; DM_MISALIGN_TRAP_EN enables misaligned-access trapping
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 4;
    localparam int CNT_W     = 2;
    localparam int DEPTH_MIN = 16;
    localparam int DEPTH_MAX = 4096;

`ifdef DM_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    // A request is rejected for the reserved size, or for a misaligned half/word when trapping is on
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_RSVD ||
               (MISALIGN_TRAP && ((size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00)));
    endfunction

endpackage

// File: rtl/dm_byte_array.sv
// dm_byte_array: big-endian byte storage, lane i addresses addr+i with wrap, four lane write enables (DM_MISALIGN_TRAP_EN not used here)
module dm_byte_array #(
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH];

    // Lane 0 is the most significant byte and lives at the lowest address
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (we[l]) mem[addr + AW'(l)] <= wdata[31-8*l -: 8];
    end

    genvar i;
    for (i = 0; i < 4; i++) begin : g_rd
        assign rdata[31-8*i -: 8] = mem[addr + AW'(i)];
    end

endmodule

// File: rtl/data_mem_sized.sv
// data_mem_sized: single-outstanding sized load/store memory; DM_MISALIGN_TRAP_EN makes misaligned half/word an error
module data_mem_sized
    import dm_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             accept;
    logic             bad;
    logic [3:0]       we;
    logic [31:0]      wd_al;
    logic [31:0]      mem_rd;
    logic [31:0]      ld;
    logic             unused_addr;

    assign unused_addr = ^req_addr[31:AW];
    assign accept      = req_valid & req_ready;
    assign bad         = req_bad(req_size, req_addr[1:0]);

    // Store data is left-justified so lane 0 lands on the addressed byte
    always_comb begin
        we    = (accept && req_we && !bad) ?
                (req_size == SZ_BYTE ? 4'b0001 : req_size == SZ_HALF ? 4'b0011 : 4'b1111) : 4'b0000;
        wd_al = req_size == SZ_BYTE ? {req_wdata[7:0], 24'b0} :
                req_size == SZ_HALF ? {req_wdata[15:0], 16'b0} : req_wdata;
        ld    = bad ? 32'b0 :
                req_size == SZ_BYTE ? {{24{~req_unsigned & mem_rd[31]}}, mem_rd[31:24]} :
                req_size == SZ_HALF ? {{16{~req_unsigned & mem_rd[31]}}, mem_rd[31:16]} : mem_rd;
    end

    dm_byte_array #(.DEPTH(DEPTH_BYTES)) u_array (
        .clk   (clk),
        .addr  (req_addr[AW-1:0]),
        .we    (we),
        .wdata (wd_al),
        .rdata (mem_rd)
    );

    // State register; load result and error are captured at accept so the response reflects memory then
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= CNT_W'(READ_LAT - 1);
                rdata_q <= req_we ? 32'b0 : ld;
                err_q   <= bad;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next state: stores acknowledge next cycle, loads wait out the counter, both return to idle on response
    always_comb begin
        state_nx = accept ? (req_we ? ST_ACK : ST_WAIT) :
                   (state == ST_ACK || (state == ST_WAIT && cnt == '0)) ? ST_IDLE : state;
    end

    // Outputs: response data and error are forced to zero outside the response pulse
    always_comb begin
        rsp_valid = state == ST_ACK || (state == ST_WAIT && cnt == '0);
        req_ready = state == ST_IDLE && !rst;
        rsp_rdata = rsp_valid ? rdata_q : 32'b0;
        rsp_err   = rsp_valid & err_q;
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized: directed table-driven bench for data_mem_sized at DEPTH_BYTES=128, READ_LAT=3
module tb_data_mem_sized;

    localparam int LAT = 3;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_sized #(.DEPTH_BYTES(128), .READ_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int idle_bad = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t v[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic err);
        vec_t r;
        r.we = we; r.sz = sz; r.uns = uns; r.addr = addr; r.wd = wd;
        r.rd = rd; r.err = err; r.lat = we ? 1 : LAT;
        return r;
    endfunction

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = -1; n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_err; lat = i;
                break;
            end
            if (rsp_rdata != 0 || rsp_err) idle_bad++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, cnt, acc, rsp, bad;
        logic        outst;

        v[0]  = mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
        v[1]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h11223344, 0);
        v[2]  = mk(0, 2'b00, 0, 32'h13, 0, 32'h00000044, 0);
        v[3]  = mk(1, 2'b00, 0, 32'h11, 32'hFFFFFF80, 32'h0, 0);
        v[4]  = mk(0, 2'b01, 0, 32'h10, 0, 32'h00001180, 0);
        v[5]  = mk(0, 2'b01, 0, 32'h11, 0, TRAP ? 32'h0 : 32'hFFFF8033, TRAP);
        v[6]  = mk(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFF80, 0);
        v[7]  = mk(0, 2'b00, 1, 32'h11, 0, 32'h00000080, 0);
        v[8]  = mk(0, 2'b10, 0, 32'hFFFFFF90, 0, 32'h11803344, 0);
        v[9]  = mk(1, 2'b10, 0, 32'h00, 32'h01020304, 32'h0, 0);
        v[10] = mk(1, 2'b10, 0, 32'h7C, 32'h00000000, 32'h0, 0);
        v[11] = mk(0, 2'b11, 0, 32'h00, 0, 32'h0, 1);
        v[12] = mk(1, 2'b11, 0, 32'h00, 32'hDEADBEEF, 32'h0, 1);
        v[13] = mk(0, 2'b10, 0, 32'h00, 0, 32'h01020304, 0);
        v[14] = mk(1, 2'b10, 0, 32'h7E, 32'hAABBCCDD, 32'h0, TRAP);
        v[15] = mk(0, 2'b00, 1, 32'h7E, 0, TRAP ? 32'h00 : 32'hAA, 0);
        v[16] = mk(0, 2'b00, 1, 32'h7F, 0, TRAP ? 32'h00 : 32'hBB, 0);
        v[17] = mk(0, 2'b00, 1, 32'h00, 0, TRAP ? 32'h01 : 32'hCC, 0);
        v[18] = mk(0, 2'b00, 1, 32'h01, 0, TRAP ? 32'h02 : 32'hDD, 0);
        v[19] = mk(0, 2'b10, 0, 32'h7E, 0, TRAP ? 32'h0 : 32'hAABBCCDD, TRAP);
        v[20] = mk(1, 2'b01, 0, 32'h02, 32'hFFFF1234, 32'h0, 0);
        v[21] = mk(0, 2'b10, 0, 32'h00, 0, TRAP ? 32'h01021234 : 32'hCCDD1234, 0);
        v[22] = mk(0, 2'b01, 1, 32'h02, 0, 32'h00001234, 0);
        v[23] = mk(0, 2'b01, 0, 32'h7F, 0, TRAP ? 32'h0 : 32'hFFFFBBCC, TRAP);
        v[24] = mk(1, 2'b10, 0, 32'h20, 32'h5555AAAA, 32'h0, 0);

        @(negedge clk); #1;
        chk("ready_in_rst", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ready", req_ready, 1);

        for (int k = 0; k < 25; k++) begin
            xact(v[k].we, v[k].sz, v[k].uns, v[k].addr, v[k].wd, rd, er, lat);
            chk($sformatf("v%0d_rdata", k), rd, v[k].rd);
            chk($sformatf("v%0d_err", k), {31'b0, er}, {31'b0, v[k].err});
            chk($sformatf("v%0d_lat", k), lat, v[k].lat);
        end

        // Store attempted while rst is high must neither be accepted nor written
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'hCAFEBABE;
        #1;
        chk("ready_low_rst", req_ready, 0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        xact(0, 2'b10, 0, 32'h20, 0, rd, er, lat);
        chk("no_write_in_rst", rd, 32'h5555AAAA);

        // Reset one cycle after a load accept drops its response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        #1;
        chk("pre_rst_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        #1 if (rsp_valid) cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);
        if (rsp_valid) cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("rst_drops_rsp", cnt, 0);

        // Continuous req_valid: one accept per response, ready low while outstanding
        acc = 0; rsp = 0; bad = 0; outst = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (outst && req_ready) bad++;
            if (rsp_valid) begin
                rsp++;
                outst = 1'b0;
                if (rsp_rdata !== 32'h11803344) bad++;
            end
            if (req_valid && req_ready) begin
                acc++;
                outst = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 if (rsp_valid) rsp++;
            @(negedge clk);
        end
        chk("stream_accepts", acc, 6);
        chk("stream_responses", rsp, 6);
        chk("stream_violations", bad, 0);
        chk("idle_outputs_zero", idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
